outdev_scan_ctrl: RTL and testbench

//  Sole master of the output-device register port (we/addr/din/dout). Arbitrates that port between
//  CPU accesses arriving from the bridge and a display scanner. The scanner snapshots one device

---
 rtl/outdev_pkg.sv | 23 ++
 rtl/hex_to_seg7.sv | 13 +
 rtl/outdev_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_outdev_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/outdev_pkg.sv
// Shared types and constants for the output-device port arbiter and display scanner.
package outdev_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCpuAcc,
        StCpuAck,
        StScanAcc
    } state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-high {g,f,e,d,c,b,a}, entry 15 first.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        return SEG7_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment decoder.
module hex_to_seg7
    import outdev_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_seg(nibble);
    end

endmodule

// File: rtl/outdev_scan_ctrl.sv
// Arbitrates the output-device register port between CPU accesses and a 7-segment scanner.
// Optional BLANK_LEADING_ZERO_EN darkens leading zero digits (digit 0 always lit).
module outdev_scan_ctrl
    import outdev_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned NDIG     = 8,
    parameter logic [1:0]  SRC_ADDR = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [1:0]      cpu_addr,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic            cpu_ack,
    output logic            dev_we,
    output logic [1:0]      dev_addr,
    output logic [31:0]     dev_din,
    input  logic [31:0]     dev_dout,
    output logic [NDIG-1:0] seg_an,
    output logic [7:0]      seg_cat
);

    localparam int unsigned DivW     = $clog2(SCAN_DIV);
    localparam int unsigned DigW     = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [31:0] DispMask = 32'hFFFF_FFFF >> (32 - 4 * NDIG);

`ifdef BLANK_LEADING_ZERO_EN
    localparam bit BlankEn = 1'b1;
`else
    localparam bit BlankEn = 1'b0;
`endif

    state_e          state_q;
    logic            we_q;
    logic [31:0]     shadow_q;
    logic            fetch_pend_q;
    logic [DivW-1:0] div_q;
    logic [DigW-1:0] digit_q;

    logic            div_wrap;
    logic            frame_wrap;
    logic [31:0]     upper;
    logic [3:0]      nibble;
    logic [6:0]      seg;
    logic            lead_zero;
    logic [NDIG-1:0] an_d;
    logic [7:0]      cat_d;

    assign div_wrap   = (div_q == DivW'(SCAN_DIV - 1));
    assign frame_wrap = div_wrap && (digit_q == DigW'(NDIG - 1));

    // Port arbiter: dev_* are registered so they are valid for the whole access cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            dev_we       <= 1'b0;
            dev_addr     <= '0;
            dev_din      <= '0;
            shadow_q     <= '0;
            fetch_pend_q <= 1'b1;
        end else begin
            cpu_ack  <= 1'b0;
            dev_we   <= 1'b0;
            dev_addr <= '0;
            dev_din  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        state_q  <= StCpuAcc;
                        we_q     <= cpu_we;
                        dev_we   <= cpu_we;
                        dev_addr <= cpu_addr;
                        dev_din  <= cpu_wdata;
                    end else if (fetch_pend_q) begin
                        state_q  <= StScanAcc;
                        dev_addr <= SRC_ADDR;
                    end
                end
                StCpuAcc: begin
                    if (!we_q) cpu_rdata <= dev_dout;
                    cpu_ack <= 1'b1;
                    state_q <= StCpuAck;
                end
                StCpuAck: begin
                    state_q <= StIdle;
                end
                StScanAcc: begin
                    shadow_q <= dev_dout;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            // A new frame request outranks completion of the previous fetch.
            if (frame_wrap) begin
                fetch_pend_q <= 1'b1;
            end else if (state_q == StScanAcc) begin
                fetch_pend_q <= 1'b0;
            end
        end
    end

    assign upper  = (shadow_q & DispMask) >> {digit_q, 2'b00};
    assign nibble = upper[3:0];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (seg)
    );

    assign lead_zero = BlankEn && (upper == '0) && (digit_q != '0);

    always_comb begin
        an_d  = ~(NDIG'(1) << digit_q);
        cat_d = lead_zero ? SEG_OFF : {1'b1, ~seg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            digit_q <= '0;
            seg_an  <= '1;
            seg_cat <= SEG_OFF;
        end else begin
            div_q <= div_wrap ? '0 : div_q + DivW'(1);
            if (div_wrap) begin
                digit_q <= (digit_q == DigW'(NDIG - 1)) ? '0 : digit_q + DigW'(1);
            end
            seg_an  <= an_d;
            seg_cat <= cat_d;
        end
    end

endmodule

// File: tb/tb_outdev_scan_ctrl.sv
// Randomized bench for outdev_scan_ctrl against a cycle-count display model and a register model.
module tb_outdev_scan_ctrl;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned NDIG     = 8;
    localparam logic [1:0]  SRC_ADDR = 2'b01;
    localparam int unsigned FRAME    = SCAN_DIV * NDIG;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        dev_we;
    logic [1:0]  dev_addr;
    logic [31:0] dev_din;
    logic [31:0] dev_dout;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] dev_regs [2];
    logic [31:0] mdl_regs [2];

    outdev_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .NDIG     (NDIG),
        .SRC_ADDR (SRC_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_din   (dev_din),
        .dev_dout  (dev_dout),
        .seg_an    (seg_an),
        .seg_cat   (seg_cat)
    );

    always #5 clk = ~clk;

    // Device: two registers, combinational read.
    initial begin
        dev_regs[0] = '0;
        dev_regs[1] = '0;
    end
    always @(posedge clk) if (dev_we) dev_regs[dev_addr[0]] <= dev_din;
    assign dev_dout = dev_regs[dev_addr[0]];

    // Rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Outputs after edge k show the digit selected after edge k-1.
    function automatic logic [7:0] exp_an(input int k);
        int d;
        if (k == 0) return 8'hFF;
        d = ((k - 1) / SCAN_DIV) % NDIG;
        return ~(8'h01 << d);
    endfunction

    function automatic logic [7:0] exp_cat(input int k, input logic [31:0] sh);
        int d;
        logic [31:0] up;
        if (k == 0) return 8'hFF;
        d  = ((k - 1) / SCAN_DIV) % NDIG;
        up = sh >> (4 * d);
`ifdef BLANK_LEADING_ZERO_EN
        if (d != 0 && up == 0) return 8'hFF;
`endif
        return {1'b1, ~ref_seg(up[3:0])};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge where cpu_ack is seen, with req dropped.
    task automatic cpu_txn(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                           input int lat_min, input int lat_max);
        int lat = 0;
        int we_cycles = 0;
        bit got = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (dev_we) begin
                we_cycles++;
                check_eq("wr_addr", {30'd0, dev_addr}, {30'd0, addr});
                check_eq("wr_data", dev_din, wdata);
            end
            if (cpu_ack) got = 1;
        end
        check_eq("ack_seen", {31'd0, got}, 32'd1);
        check_eq("ack_latency", {31'd0, lat >= lat_min && lat <= lat_max}, 32'd1);
        check_eq("we_pulses", we_cycles, {31'd0, we});
        if (we) mdl_regs[addr[0]] = wdata;
        else    check_eq("rdata", cpu_rdata, mdl_regs[addr[0]]);
        cpu_req = 1'b0;
    endtask

    // Quiet bus: a full frame after a fresh fetch must show sh.
    task automatic check_frame(input logic [31:0] sh);
        do @(negedge clk); while (cyc % FRAME != 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            check_eq("scan_an", {24'd0, seg_an}, {24'd0, exp_an(cyc)});
            check_eq("scan_cat", {24'd0, seg_cat}, {24'd0, exp_cat(cyc, sh)});
        end
    endtask

    initial begin
        #300000;
        $display("[TB] timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old_sh;
        logic [31:0] d;
        int gap;
        int n;
        mdl_regs[0] = '0;
        mdl_regs[1] = '0;

        // Reset values, then first fetch right after release.
        repeat (3) @(negedge clk);
        check_eq("rst_an", {24'd0, seg_an}, 32'hFF);
        check_eq("rst_cat", {24'd0, seg_cat}, 32'hFF);
        check_eq("rst_ack", {31'd0, cpu_ack}, 32'd0);
        check_eq("rst_we", {31'd0, dev_we}, 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);
        check_eq("rst_daddr", {30'd0, dev_addr}, 32'd0);
        check_eq("rst_din", dev_din, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("first_scan_addr", {30'd0, dev_addr}, {30'd0, SRC_ADDR});
        check_eq("first_scan_we", {31'd0, dev_we}, 32'd0);
        @(negedge clk);
        check_eq("post_scan_addr", {30'd0, dev_addr}, 32'd0);

        // Reset mid-frame.
        do @(negedge clk); while (cyc != 13);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_an", {24'd0, seg_an}, 32'hFF);
        check_eq("midrst_cat", {24'd0, seg_cat}, 32'hFF);
        check_eq("midrst_ack", {31'd0, cpu_ack}, 32'd0);
        check_eq("midrst_we", {31'd0, dev_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_scan_addr", {30'd0, dev_addr}, {30'd0, SRC_ADDR});
        check_frame(mdl_regs[1]);

        // Write then read back, exact latency on an idle port.
        cpu_txn(1'b1, 2'd1, 32'h1234_5678, 2, 2);
        @(negedge clk);
        check_eq("ack_one_cycle", {31'd0, cpu_ack}, 32'd0);
        cpu_txn(1'b0, 2'd1, 32'd0, 2, 2);
        check_frame(32'h1234_5678);

        // Collision: request in the cycle fetch_pend rises.
        do @(negedge clk); while (cyc % FRAME != 0);
        d = $urandom;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd0; cpu_wdata = d;
        @(negedge clk);
        check_eq("coll_cpu_we", {31'd0, dev_we}, 32'd1);
        check_eq("coll_cpu_addr", {30'd0, dev_addr}, 32'd0);
        check_eq("coll_cpu_din", dev_din, d);
        @(negedge clk);
        check_eq("coll_ack", {31'd0, cpu_ack}, 32'd1);
        cpu_req = 1'b0;
        mdl_regs[0] = d;
        @(negedge clk);
        check_eq("coll_idle_addr", {30'd0, dev_addr}, 32'd0);
        @(negedge clk);
        check_eq("coll_scan_addr", {30'd0, dev_addr}, {30'd0, SRC_ADDR});
        check_eq("coll_scan_we", {31'd0, dev_we}, 32'd0);
        check_frame(mdl_regs[1]);

        // Starvation: back-to-back requests across a frame keep the old shadow.
        old_sh = mdl_regs[1];
        cpu_txn(1'b1, 2'd1, 32'hCAFE_0042, 2, 2);
        for (int i = 0; i < 24; i++) begin
            cpu_txn(1'($urandom_range(0, 1)), 2'd0, $urandom, 3, 3);
            check_eq("starve_an", {24'd0, seg_an}, {24'd0, exp_an(cyc)});
            check_eq("starve_cat", {24'd0, seg_cat}, {24'd0, exp_cat(cyc, old_sh)});
        end
        check_frame(32'hCAFE_0042);

        // Leading zeros.
        cpu_txn(1'b1, 2'd1, 32'h0000_00A0, 2, 2);
        check_frame(32'h0000_00A0);

        // Random traffic with random gaps.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(6, 10);
            gap = -1;
            for (int i = 0; i < n; i++) begin
                d = $urandom >> (4 * $urandom_range(0, 7));
                if (gap < 0)       cpu_txn(1'($urandom_range(0, 1)), 2'($urandom), d, 2, 2);
                else if (gap == 0) cpu_txn(1'($urandom_range(0, 1)), 2'($urandom), d, 3, 3);
                else if (gap == 1) cpu_txn(1'($urandom_range(0, 1)), 2'($urandom), d, 2, 2);
                else               cpu_txn(1'($urandom_range(0, 1)), 2'($urandom), d, 2, 3);
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
            end
            check_frame(mdl_regs[1]);
        end

        // Reset during the access cycle of a write: no ack, then re-issue.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd1; cpu_wdata = 32'h5555_AAAA;
        @(negedge clk);
        check_eq("abort_we_before", {31'd0, dev_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_we", {31'd0, dev_we}, 32'd0);
        check_eq("abort_ack", {31'd0, cpu_ack}, 32'd0);
        check_eq("abort_rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("abort_no_ack", {31'd0, cpu_ack}, 32'd0);
        end
        rst_n = 1'b1;
        cpu_txn(1'b1, 2'd1, 32'h5555_AAAA, 2, 2);
        cpu_txn(1'b0, 2'd1, 32'd0, 3, 3);
        check_frame(32'h5555_AAAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
